// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use detection and long-latency scoreboard for the EX stage.
// Nearest producer stage wins; the scoreboard tracks mul/div destinations in flight.
module fwd_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int N_STAGES = 2,
    parameter int SEL_W    = $clog2(N_STAGES + 1),
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [REG_AW-1:0]            ex_rs1,
    input  logic [REG_AW-1:0]            ex_rs2,
    input  logic [N_STAGES*REG_AW-1:0]   stg_rd,
    input  logic [N_STAGES-1:0]          stg_wen,
    input  logic [N_STAGES-1:0]          stg_rdy,
    input  logic                         id_valid,
    input  logic [REG_AW-1:0]            id_rs1,
    input  logic [REG_AW-1:0]            id_rs2,
    input  logic [REG_AW-1:0]            id_rd,
    input  logic                         id_rs1_used,
    input  logic                         id_rs2_used,
    input  logic                         id_rd_used,
    input  logic                         lat_issue,
    input  logic                         lat_done,
    input  logic [REG_AW-1:0]            lat_done_rd,
    input  logic                         flush,
    output logic [SEL_W-1:0]             forward_a,
    output logic [SEL_W-1:0]             forward_b,
    output logic                         stall_ex,
    output logic                         stall_id,
    output logic [(1<<REG_AW)-1:0]       pending,
    output logic [CNT_W-1:0]             stall_cnt
);

    localparam int NREG = 1 << REG_AW;

    logic              rdy_a;
    logic              rdy_b;
    logic [NREG-1:0]   pending_eff;
    logic [NREG-1:0]   pending_nxt;

    // Walk from the oldest stage to the youngest so the nearest hit overwrites older ones.
    always_comb begin
        forward_a = '0;
        forward_b = '0;
        rdy_a     = 1'b1;
        rdy_b     = 1'b1;
        for (int k = N_STAGES; k >= 1; k--) begin
            if (stg_wen[k-1] && (stg_rd[k*REG_AW-1 -: REG_AW] != '0)) begin
                if (stg_rd[k*REG_AW-1 -: REG_AW] == ex_rs1) begin
                    forward_a = SEL_W'(k);
                    rdy_a     = stg_rdy[k-1];
                end
                if (stg_rd[k*REG_AW-1 -: REG_AW] == ex_rs2) begin
                    forward_b = SEL_W'(k);
                    rdy_b     = stg_rdy[k-1];
                end
            end
        end
    end

    assign stall_ex = ~rdy_a | ~rdy_b;

    // A result delivered this cycle no longer blocks ID; its value arrives by forwarding.
    always_comb begin
        pending_eff = pending;
        if (lat_done) begin
            pending_eff[lat_done_rd] = 1'b0;
        end
    end

    assign stall_id = id_valid & ((id_rs1_used & pending_eff[id_rs1]) |
                                  (id_rs2_used & pending_eff[id_rs2]) |
                                  (id_rd_used  & pending_eff[id_rd]));

    // Clear first, then set, so a same-cycle reissue keeps the register marked busy.
    always_comb begin
        pending_nxt = pending;
        if (lat_done) begin
            pending_nxt[lat_done_rd] = 1'b0;
        end
        if (lat_issue && !flush && (id_rd != '0)) begin
            pending_nxt[id_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending   <= '0;
            stall_cnt <= '0;
        end else begin
            pending <= pending_nxt;
            if ((stall_ex || stall_id) && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic against a rule-level model.
module tb_fwd_hazard_unit;

    localparam int REG_AW = 5;
    localparam int N_ST   = 2;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 4;
    localparam int NREG   = 1 << REG_AW;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [REG_AW-1:0]         ex_rs1, ex_rs2;
    logic [N_ST*REG_AW-1:0]    stg_rd;
    logic [N_ST-1:0]           stg_wen, stg_rdy;
    logic                      id_valid;
    logic [REG_AW-1:0]         id_rs1, id_rs2, id_rd;
    logic                      id_rs1_used, id_rs2_used, id_rd_used;
    logic                      lat_issue, lat_done, flush;
    logic [REG_AW-1:0]         lat_done_rd;
    logic [SEL_W-1:0]          forward_a, forward_b;
    logic                      stall_ex, stall_id;
    logic [NREG-1:0]           pending;
    logic [CNT_W-1:0]          stall_cnt;

    int checks = 0;
    int failures = 0;

    bit model_pend [NREG];
    int model_cnt;

    fwd_hazard_unit #(.REG_AW(REG_AW), .N_STAGES(N_ST), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .stg_rd(stg_rd), .stg_wen(stg_wen), .stg_rdy(stg_rdy),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd_used(id_rd_used),
        .lat_issue(lat_issue), .lat_done(lat_done), .lat_done_rd(lat_done_rd), .flush(flush),
        .forward_a(forward_a), .forward_b(forward_b), .stall_ex(stall_ex), .stall_id(stall_id),
        .pending(pending), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int expSel(input logic [REG_AW-1:0] rs);
        logic [REG_AW-1:0] rd;
        for (int k = 1; k <= N_ST; k++) begin
            rd = stg_rd[k*REG_AW-1 -: REG_AW];
            if (stg_wen[k-1] && rd != 0 && rd == rs) return k;
        end
        return 0;
    endfunction

    function automatic bit expStallEx();
        int sa, sb;
        sa = expSel(ex_rs1);
        sb = expSel(ex_rs2);
        return (sa != 0 && !stg_rdy[sa-1]) || (sb != 0 && !stg_rdy[sb-1]);
    endfunction

    function automatic bit busy(input logic [REG_AW-1:0] r);
        if (lat_done && lat_done_rd == r) return 1'b0;
        return model_pend[r];
    endfunction

    function automatic bit expStallId();
        if (!id_valid) return 1'b0;
        return (id_rs1_used && busy(id_rs1)) || (id_rs2_used && busy(id_rs2)) ||
               (id_rd_used && busy(id_rd));
    endfunction

    function automatic logic [NREG-1:0] packPend();
        logic [NREG-1:0] v;
        for (int r = 0; r < NREG; r++) v[r] = model_pend[r];
        return v;
    endfunction

    task automatic clearInputs();
        ex_rs1 = '0; ex_rs2 = '0; stg_rd = '0; stg_wen = '0; stg_rdy = '1;
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rd_used = 1'b0;
        lat_issue = 1'b0; lat_done = 1'b0; lat_done_rd = '0; flush = 1'b0;
    endtask

    task automatic checkCycle();
        @(negedge clk);
        checkOutput("forward_a", 64'(forward_a), 64'(expSel(ex_rs1)));
        checkOutput("forward_b", 64'(forward_b), 64'(expSel(ex_rs2)));
        checkOutput("stall_ex", 64'(stall_ex), 64'(expStallEx()));
        checkOutput("stall_id", 64'(stall_id), 64'(expStallId()));
        checkOutput("pending", 64'(pending), 64'(packPend()));
        checkOutput("stall_cnt", 64'(stall_cnt), 64'(model_cnt));
    endtask

    task automatic tickCycle();
        bit st;
        @(posedge clk);
        if (!rst_n) begin
            foreach (model_pend[r]) model_pend[r] = 1'b0;
            model_cnt = 0;
        end else begin
            st = expStallEx() || expStallId();
            if (st && model_cnt < CMAX) model_cnt++;
            if (lat_done) model_pend[lat_done_rd] = 1'b0;
            if (lat_issue && !flush && id_rd != 0) model_pend[id_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic applyStimulus();
        rst_n       = ($urandom_range(0, 31) != 0);
        ex_rs1      = REG_AW'($urandom_range(0, 7));
        ex_rs2      = REG_AW'($urandom_range(0, 7));
        stg_rd      = {REG_AW'($urandom_range(0, 7)), REG_AW'($urandom_range(0, 7))};
        stg_wen     = N_ST'($urandom);
        stg_rdy     = N_ST'($urandom);
        id_valid    = 1'($urandom);
        id_rs1      = REG_AW'($urandom_range(0, 7));
        id_rs2      = REG_AW'($urandom_range(0, 7));
        id_rd       = REG_AW'($urandom_range(0, 7));
        id_rs1_used = 1'($urandom);
        id_rs2_used = 1'($urandom);
        id_rd_used  = 1'($urandom);
        lat_issue   = 1'($urandom);
        lat_done    = 1'($urandom);
        lat_done_rd = REG_AW'($urandom_range(0, 7));
        flush       = ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        clearInputs();
        rst_n = 1'b0;
        model_cnt = 0;
        foreach (model_pend[r]) model_pend[r] = 1'b0;
        tickCycle();
        tickCycle();
        rst_n = 1'b1;
        checkOutput("reset_pending", 64'(pending), 64'd0);
        checkOutput("reset_cnt", 64'(stall_cnt), 64'd0);

        // forwarding priority
        ex_rs1 = 5; stg_rd = {5'd5, 5'd5}; stg_wen = 2'b11; stg_rdy = 2'b11;
        checkCycle(); checkOutput("prio_stage1", 64'(forward_a), 64'd1); tickCycle();
        stg_wen = 2'b10;
        checkCycle(); checkOutput("prio_stage2", 64'(forward_a), 64'd2); tickCycle();
        ex_rs1 = 0; stg_rd = '0; stg_wen = 2'b11;
        checkCycle(); checkOutput("prio_x0", 64'(forward_a), 64'd0); tickCycle();

        // load-use
        clearInputs();
        stg_rd = {5'd7, 5'd7}; stg_wen = 2'b11; stg_rdy = 2'b10; ex_rs2 = 7;
        checkCycle();
        checkOutput("lu_fwd_b", 64'(forward_b), 64'd1);
        checkOutput("lu_stall", 64'(stall_ex), 64'd1);
        tickCycle();
        stg_rdy = 2'b11;
        checkCycle(); checkOutput("lu_release", 64'(stall_ex), 64'd0); tickCycle();
        checkOutput("lu_cnt", 64'(stall_cnt), 64'd1);

        // scoreboard RAW with same-cycle bypass of the clear
        clearInputs();
        lat_issue = 1; id_rd = 9;
        checkCycle(); tickCycle();
        lat_issue = 0; id_rd = 0; id_valid = 1; id_rs1 = 9; id_rs1_used = 1;
        checkCycle();
        checkOutput("raw_stall", 64'(stall_id), 64'd1);
        checkOutput("raw_pend9", 64'(pending[9]), 64'd1);
        tickCycle();
        checkCycle(); tickCycle();
        lat_done = 1; lat_done_rd = 9;
        checkCycle(); checkOutput("raw_bypass", 64'(stall_id), 64'd0); tickCycle();
        lat_done = 0;
        checkCycle(); checkOutput("raw_cleared", 64'(pending[9]), 64'd0); tickCycle();

        // WAW and x0 issue
        clearInputs();
        lat_issue = 1; id_rd = 12;
        checkCycle(); tickCycle();
        lat_issue = 0; id_valid = 1; id_rd_used = 1;
        checkCycle(); checkOutput("waw_stall", 64'(stall_id), 64'd1); tickCycle();
        clearInputs();
        lat_issue = 1; id_rd = 0;
        checkCycle(); tickCycle();
        checkOutput("x0_ignored", 64'(pending), 64'(32'h1 << 12));

        // simultaneous issue/done and flush
        clearInputs();
        lat_done = 1; lat_done_rd = 12;
        checkCycle(); tickCycle();
        lat_issue = 1; id_rd = 4; lat_done = 1; lat_done_rd = 4;
        checkCycle(); tickCycle();
        checkOutput("set_wins", 64'(pending), 64'(32'h1 << 4));
        clearInputs();
        lat_issue = 1; id_rd = 6; flush = 1;
        checkCycle(); tickCycle();
        checkOutput("flush_cancel", 64'(pending), 64'(32'h1 << 4));

        // saturation then reset
        clearInputs();
        ex_rs1 = 3; stg_rd = {5'd0, 5'd3}; stg_wen = 2'b01; stg_rdy = 2'b00;
        for (int i = 0; i < 20; i++) begin
            checkCycle(); tickCycle();
        end
        checkOutput("sat_cnt", 64'(stall_cnt), 64'(CMAX));
        rst_n = 1'b0;
        checkCycle(); tickCycle();
        rst_n = 1'b1;
        checkOutput("rst_cnt", 64'(stall_cnt), 64'd0);
        checkOutput("rst_pending", 64'(pending), 64'd0);
        clearInputs();
        lat_done = 1; lat_done_rd = 4;
        checkCycle(); tickCycle();
        checkOutput("done_noop", 64'(pending), 64'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus();
            checkCycle();
            tickCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard controller for the pipelined RISC-V core. It generalises operand forwarding to N producer stages with nearest-stage priority. It adds data-not-ready (load-use) stall detection, and a registered scoreboard that tracks long-latency writes (mul/div) in flight. It sits beside the ID/EX stages, drives the EX operand muxes, and drives the stall/bubble controls of the hazard logic.

## Interface
Parameters:
- REG_AW, 5, register address width (2^REG_AW architectural registers; x0 hard-wired zero)
- N_STAGES, 2, number of forwarding source stages after EX (stage 1 = EX/MEM, stage N = last writeback)
- SEL_W, $clog2(N_STAGES+1), width of forward selects
- CNT_W, 16, stall statistics counter width

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; synchronous and active-low
- ex_rs1, ex_rs2  in  REG_AW each  source registers of the instruction in EX
- stg_rd  in  N_STAGES*REG_AW  destination per stage, stage k at bits [k*REG_AW-1 -: REG_AW]
- stg_wen  in  N_STAGES  register-write enable per stage
- stg_rdy  in  N_STAGES  result valid in that stage (0 = load data not yet returned)
- id_valid  in  1  a valid instruction is in ID
- id_rs1, id_rs2, id_rd  in  REG_AW each  ID-stage register fields
- id_rs1_used, id_rs2_used, id_rd_used  in  1 each  field is actually read/written
- lat_issue  in  1  a long-latency op leaves ID this cycle, writing id_rd
- lat_done  in  1  long-latency unit delivers its result this cycle
- lat_done_rd  in  REG_AW  destination of the delivered result
- flush  in  1  pipeline flush; cancels a same-cycle lat_issue
- forward_a, forward_b  out  SEL_W each  0 = register file, k = stage k
- stall_ex  out  1  hold ID/EX, insert bubble into stage 1
- stall_id  out  1  hold PC/IF/ID because of a scoreboard hazard
- pending  out  2^REG_AW  scoreboard bitmap
- stall_cnt  out  CNT_W  saturating count of cycles with any stall asserted

## Operation
- Stage k is a forwarding hit for rs when stg_wen[k]=1, stg_rd[k]!=0 and stg_rd[k]==rs.
- forward_a/forward_b select the lowest-numbered hit stage, so the youngest producer wins. With no hit, or rs==0, the select is 0.
- Load-use: if the selected stage for either operand has stg_rdy=0, stall_ex=1 and the select still points at that stage. If stage 1 misses data but stage 2 has it for the same register, stage 2 is not used; the stall stands.
- Scoreboard: pending[r] set on clk when lat_issue=1, flush=0 and id_rd!=0 (r=id_rd). pending[r] is cleared on clk when lat_done=1 (r=lat_done_rd).
- Same-cycle issue and done to the same register: set wins, because a new producer is now in flight.
- pending[0] is never set.
- stall_id=1 when id_valid=1 and any of the following holds:
  - id_rs1_used with pending[id_rs1] (RAW)
  - id_rs2_used with pending[id_rs2] (RAW)
  - id_rd_used with pending[id_rd] (WAW)
- A register whose lat_done is asserted this cycle is treated as not pending for stall_id, giving a combinational bypass of the clear. Its value reaches EX via stage forwarding.
- stall_cnt increments when stall_ex|stall_id and saturates at all-ones.
- flush does not clear pending, because issued long-latency ops still complete.

## Timing
- forward_a, forward_b, stall_ex and stall_id are combinational, with zero latency from inputs.
- pending and stall_cnt are registered and update on the rising clk edge.
- A lat_issue in cycle t makes pending visible, and able to stall a dependent op, from cycle t+1.
- Reset (rst_n=0 at an edge): pending=0 and stall_cnt=0.
- Combinational outputs follow the inputs during reset. With pending=0 they carry no scoreboard stall.
- Reset mid-operation discards all in-flight tracking. A lat_done arriving after reset on a non-pending register is a no-op.
- Boundary cases:
  - stall_cnt at max stays max.
  - Issue with id_rd=0 is ignored.
  - Duplicate issue to an already-pending register is legal; pending stays 1 and the WAW stall normally prevents it.

## Test plan
- Forwarding priority: N_STAGES=2, ex_rs1=5, stage1 rd=5 wen=1 rdy=1, stage2 rd=5 wen=1 → forward_a=1. Then stage1 wen=0 → forward_a=2. Then ex_rs1=0 with both stages rd=0 wen=1 → forward_a=0.
- Load-use: stage1 rd=7 wen=1 rdy=0, ex_rs2=7 → forward_b=1, stall_ex=1. Next cycle rdy=1 → stall_ex=0. stall_cnt advances by exactly 1.
- Scoreboard RAW: lat_issue with id_rd=9 at t. At t+1, id_valid=1, id_rs1=9 used → stall_id=1 and pending[9]=1. lat_done_rd=9 at t+3 → stall_id=0 in that same cycle, and pending[9]=0 at t+4.
- WAW and x0: issue to rd=12, then ID with id_rd=12 used → stall_id=1. lat_issue with id_rd=0 → pending unchanged.
- Simultaneous and flush: lat_issue rd=4 with lat_done rd=4 in one cycle → pending[4]=1. lat_issue with flush=1 → no bit set.
- Reset and saturation: CNT_W=4, hold stall_ex for 20 cycles → stall_cnt=15. Drop rst_n for one edge → stall_cnt=0 and pending=0.
